mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit holding the architectural HI/LO registers for the multi-cycle MIPS core. It sits beside the ALU in the execute stage. The control FSM raises `Start` with an opcode during EXEC_1. The unit drives `stall` back to the FSM, which holds EXEC_1 until a 32-iteration multiply or divide has committed HI/LO. `Hi` and `Lo` feed the register write-back path for MFHI/MFLO.

## Interface
Parameters:
- `ITER`, 32: iterations per MULT/DIV. Fixed at 32; the width rules below depend on it.

Ports:
- `clk`  in  1  clock.
- `Rst`  in  1  reset, synchronous, active-high.
- `Start`  in  1  request from control FSM; held high for the whole of EXEC_1.
- `Op`  in  3  `mdu_op_t`: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6–7 reserved.
- `A`  in  32  rs operand (dividend / multiplicand / MTxx source).
- `B`  in  32  rt operand (divisor / multiplier).
- `stall`  out  1  holds control FSM in EXEC_1.
- `Hi`  out  32  HI register.
- `Lo`  out  32  LO register.

## Operation
States:
- IDLE.
- BUSY: iteration counter `cnt`, 5 bits.
- DONE.

IDLE:
- `Start` with Op MULT/MULTU/DIV/DIVU latches `A`, `B` and operand signs, sets cnt=0, and moves to BUSY.
- `Start` with MTHI writes Hi<=A at that edge and stays in IDLE. MTLO writes Lo<=A and stays in IDLE.
- Reserved Op or `Start`=0: no action.

BUSY:
- One radix-2 step per edge. cnt increments.
- On the edge with cnt==31: final step, Hi/Lo commit, and state moves to DONE.

DONE:
- Unconditionally returns to IDLE on the next edge.
- `Start` is ignored here, because it is still the same instruction.

Arithmetic rules:
- Signed ops (MULT, DIV) run on magnitudes of A and B.
- Multiply: shift-add over a 64-bit accumulator. For MULT, the product is negated if sign(A)^sign(B). Result {Hi,Lo}=product.
- Divide: restoring division. Lo=quotient, Hi=remainder. For DIV, the quotient is negated if sign(A)^sign(B), and the remainder takes sign(A).
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Divide by zero, either signedness: Hi=A, Lo=0xFFFFFFFF. Negation is not applied. Takes the same 32 cycles.
- HI/LO are untouched until the final commit edge. A partially computed result is never visible.

## Timing
`stall` is combinational:
- stall = !Rst && ((state==IDLE && Start && Op∈{0..3}) || state==BUSY).

Long-op cycle sequence:
- Cycle 0 (IDLE, Start): stall=1.
- Cycles 1–32 (BUSY): stall=1.
- Cycle 33 (DONE): stall=0, and Hi/Lo hold the new result.
- The FSM leaves EXEC_1 at the end of cycle 33.
- EXEC_1 therefore lasts 34 cycles and stall is high for exactly 33.

MTHI/MTLO:
- stall is never asserted.
- The write is visible in the cycle after the Start edge.

Reset:
- Rst mid-operation forces state=IDLE, cnt=0, Hi=0, Lo=0, and stall=0 in the same cycle.
- A `Start` present while Rst is high is ignored.
- The accumulator and operand registers need no reset.

Operand capture:
- `A` and `B` are only sampled at the accepting edge.
- Changes on them during BUSY have no effect.

## Structure
- Package `mdu_pkg`: the `mdu_op_t` enum (encodings above), the `mdu_state_t` enum {IDLE, BUSY, DONE}, and the localparam for the divide-by-zero Lo value.
- Shared with the control FSM: it imports `mdu_op_t` to drive `Op`.
- Natural sub-module: `mdu_div_core`, the restoring-divide step datapath (remainder/quotient registers plus trial subtract).
- Multiply stays inline in the top level.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF → stall high 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001.
- MULT A=0xFFFFFFFD (−3) B=5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1.
- DIV A=0xFFFFFFF9 (−7) B=2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- DIVU A=7 B=0 → Hi=7, Lo=0xFFFFFFFF after 33 stall cycles, with Hi/Lo unchanged before the commit edge.
- MTHI A=0x00001234, then MTLO A=0xCAFE0000 on consecutive Start cycles → stall never high; Hi/Lo updated one edge after each.
- Rst asserted at BUSY cnt=10 of a MULT → same-cycle stall=0; next cycle Hi=Lo=0 and state=IDLE. A following MULTU 2×3 gives Lo=6, Hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit and the control FSM that drives it.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mdu_state_t;

  // LO value left behind by a divide whose divisor is zero.
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  // Absolute value of a two's complement operand when the op is signed.
  function automatic logic [31:0] magnitude(input logic [31:0] value, input logic is_signed);
    return (is_signed && value[31]) ? -value : value;
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-divide step datapath: one quotient bit per step on magnitudes.
module mdu_div_core (
  input  logic        clk,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quo_next
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvsr_q;
  logic [32:0] shifted;
  logic [31:0] rem_sub;
  logic        fits;

  // The partial remainder is always below the divisor, so the trial
  // difference fits in 32 bits whenever the subtraction is accepted.
  assign shifted  = {rem_q, quo_q[31]};
  assign fits     = (shifted >= {1'b0, dvsr_q});
  assign rem_sub  = shifted[31:0] - dvsr_q;
  assign rem_next = fits ? rem_sub : shifted[31:0];
  assign quo_next = {quo_q[30:0], fits};

  // Load the operands on acceptance, then advance one restoring step per edge.
  always_ff @(posedge clk) begin
    if (load) begin
      rem_q  <= 32'd0;
      quo_q  <= dividend;
      dvsr_q <= divisor;
    end else if (step) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Start,
  input  mdu_op_t     Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  mdu_state_t  state;
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        long_op;
  logic        signed_op;
  logic        accept;
  logic        last_step;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        div_zero;
  logic [31:0] a_raw;

  logic [63:0] prod;
  logic [63:0] prod_next;
  logic [31:0] mcand;
  logic [32:0] add_sum;
  logic [63:0] mul_res;

  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] commit_hi;
  logic [31:0] commit_lo;

  assign long_op   = (Op == OP_MULT) || (Op == OP_MULTU) || (Op == OP_DIV) || (Op == OP_DIVU);
  assign signed_op = (Op == OP_MULT) || (Op == OP_DIV);
  assign accept    = Start && long_op && (state == IDLE);
  assign last_step = (cnt == 5'(ITER - 1));
  assign a_mag     = magnitude(A, signed_op);
  assign b_mag     = magnitude(B, signed_op);

  assign stall = !Rst && (accept || (state == BUSY));
  assign Hi    = hi_q;
  assign Lo    = lo_q;

  // Shift-add: conditionally add the multiplicand into the upper half, then
  // shift the whole accumulator right, consuming one multiplier bit.
  assign add_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
  assign prod_next = {add_sum, prod[31:1]};
  assign mul_res   = neg_res ? -prod_next : prod_next;

  mdu_div_core u_div_core (
    .clk      (clk),
    .load     (accept),
    .step     (state == BUSY),
    .dividend (a_mag),
    .divisor  (b_mag),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Select the final HI/LO values from the last step's results, applying sign fix-up.
  always_comb begin
    commit_hi = mul_res[63:32];
    commit_lo = mul_res[31:0];
    if (is_div) begin
      if (div_zero) begin
        commit_hi = a_raw;
        commit_lo = DIV_ZERO_LO;
      end else begin
        commit_hi = neg_rem ? -rem_next : rem_next;
        commit_lo = neg_res ? -quo_next : quo_next;
      end
    end
  end

  // Capture operands and sign bookkeeping on acceptance, then iterate the multiplier.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div   <= (Op == OP_DIV) || (Op == OP_DIVU);
      neg_res  <= signed_op && (A[31] ^ B[31]);
      neg_rem  <= signed_op && A[31];
      div_zero <= (B == 32'd0);
      a_raw    <= A;
      mcand    <= a_mag;
      prod     <= {32'd0, b_mag};
    end else if (state == BUSY) begin
      prod <= prod_next;
    end
  end

  // Control FSM: accept ops in IDLE, count iterations in BUSY, commit HI/LO on the last step.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (Op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                cnt   <= 5'd0;
                state <= BUSY;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt <= cnt + 5'd1;
          if (last_step) begin
            hi_q  <= commit_hi;
            lo_q  <= commit_lo;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
